// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal byte FIFO and a runtime frame format
// (5-8 data bits, none/odd/even parity, 1 or 2 stop bits), frames sent back-to-back.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [DIV_WIDTH-1:0]         uart_tx_baud_div_i,
    input  logic [1:0]                   uart_tx_data_bits_i,
    input  logic [1:0]                   uart_tx_parity_i,
    input  logic                         uart_tx_stop_bits_i,
    input  logic [7:0]                   uart_tx_data_i,
    input  logic                         uart_tx_data_vld_i,
    output logic                         uart_tx_data_rdy_o,
    input  logic                         uart_tx_flush_i,
    output logic                         uart_tx_o,
    output logic                         uart_tx_busy_o,
    output logic                         uart_tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]  uart_tx_fifo_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 push, pop, pop_ok;
    logic [7:0]           rd_data, data_mask;

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end, last_data;

    logic [7:0]           shift_q, shift_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]           nbits_q, nbits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;

    assign uart_tx_data_rdy_o = (cnt_q != FULL);
    assign push      = uart_tx_data_vld_i && uart_tx_data_rdy_o && !uart_tx_flush_i;
    // A flush in the same cycle makes the FIFO look empty to the FSM.
    assign pop_ok    = (cnt_q != '0) && !uart_tx_flush_i;
    assign rd_data   = mem_q[rd_ptr_q];
    assign data_mask = 8'hFF >> (2'd3 - uart_tx_data_bits_i);
    assign bit_end   = (baud_q == div_q);
    assign last_data = (bit_q == ({1'b0, nbits_q} + 3'd4));

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        div_d     = div_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q != S_IDLE && !bit_end) begin
            baud_d = baud_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                pop = pop_ok;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (stop2_q && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        pop     = pop_ok;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Configuration is sampled only when a frame begins.
        if (pop) begin
            state_d   = S_START;
            baud_d    = '0;
            bit_d     = '0;
            shift_d   = rd_data;
            div_d     = uart_tx_baud_div_i;
            nbits_d   = uart_tx_data_bits_i;
            stop2_d   = uart_tx_stop_bits_i;
            par_en_d  = (uart_tx_parity_i == 2'd1) || (uart_tx_parity_i == 2'd2);
            par_bit_d = (^(rd_data & data_mask)) ^ (uart_tx_parity_i == 2'd1);
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (uart_tx_flush_i) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q   <= shift_d;
        div_q     <= div_d;
        nbits_q   <= nbits_d;
        par_en_q  <= par_en_d;
        par_bit_q <= par_bit_d;
        stop2_q   <= stop2_d;
        if (push) mem_q[wr_ptr_q] <= uart_tx_data_i;
    end

    assign uart_tx_o          = tx_q;
    assign uart_tx_busy_o     = (state_q != S_IDLE);
    assign uart_tx_done_o     = done_q;
    assign uart_tx_fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, parity, FIFO limits, config latching, flush, reset.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div;
    logic [1:0]  dbits;
    logic [1:0]  par;
    logic        stop2;
    logic [7:0]  data;
    logic        vld;
    logic        rdy;
    logic        flush;
    logic        tx;
    logic        busy;
    logic        done;
    logic [2:0]  cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;

    uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .uart_tx_baud_div_i  (div),
        .uart_tx_data_bits_i (dbits),
        .uart_tx_parity_i    (par),
        .uart_tx_stop_bits_i (stop2),
        .uart_tx_data_i      (data),
        .uart_tx_data_vld_i  (vld),
        .uart_tx_data_rdy_o  (rdy),
        .uart_tx_flush_i     (flush),
        .uart_tx_o           (tx),
        .uart_tx_busy_o      (busy),
        .uart_tx_done_o      (done),
        .uart_tx_fifo_cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] d, input logic [1:0] b, input logic [1:0] p, input logic s);
        div = d; dbits = b; par = p; stop2 = s;
    endtask

    task automatic push(input logic [7:0] b);
        data = b;
        vld  = 1'b1;
        @(posedge clk); #1;
        vld  = 1'b0;
    endtask

    // seq[0] is the first level on the line; each level must hold for d+1 cycles.
    task automatic expect_frame(input logic [15:0] seq, input int n, input int d,
                                input bit immediate, input string tag);
        int   budget;
        logic got;
        bit   first;
        @(negedge clk);
        if (!immediate) begin
            budget = 0;
            while (tx !== 1'b0 && budget < 500) begin
                @(negedge clk);
                budget++;
            end
        end
        first = 1'b1;
        for (int b = 0; b < n; b++) begin
            got = seq[b];
            for (int c = 0; c <= d; c++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                if (tx !== seq[b]) got = tx;
            end
            check($sformatf("%s bit%0d", tag, b), 32'(got), 32'(seq[b]));
        end
    endtask

    task automatic expect_end(input string tag);
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " idle_line"}, 32'(tx), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; flush = 1'b0; data = 8'h00;
        set_cfg(16'd3, 2'd3, 2'd0, 1'b0);
        #12;
        check("reset tx", 32'(tx), 32'd1);
        check("reset rdy", 32'(rdy), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset cnt", 32'(cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 8N1, div 3, 0x55
        done_base = done_cnt;
        push(8'h55);
        check("8n1 cnt_after_push", 32'(cnt), 32'd1);
        @(negedge clk);
        check("8n1 line_before_start", 32'(tx), 32'd1);
        expect_frame({1'b1, 8'h55, 1'b0}, 10, 3, 1'b1, "8n1");
        check("8n1 cnt_after_pop", 32'(cnt), 32'd0);
        expect_end("8n1");
        @(negedge clk);
        check("8n1 done_cleared", 32'(done), 32'd0);
        check("8n1 done_count", 32'(done_cnt - done_base), 32'd1);

        // 7E2, div 1, 0x41: parity 0
        set_cfg(16'd1, 2'd2, 2'd2, 1'b1);
        push(8'h41);
        @(negedge clk);
        expect_frame({1'b1, 1'b1, 1'b0, 7'h41, 1'b0}, 11, 1, 1'b1, "7e2");
        expect_end("7e2");

        // 8O1, div 1, 0x00: parity 1
        set_cfg(16'd1, 2'd3, 2'd1, 1'b0);
        @(negedge clk);
        push(8'h00);
        @(negedge clk);
        expect_frame({1'b1, 1'b1, 8'h00, 1'b0}, 11, 1, 1'b1, "8o1");
        expect_end("8o1");

        // FIFO full and back-to-back frames, div 15, 8N1
        set_cfg(16'd15, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        done_base = done_cnt;
        push(8'hA1);
        fork
            begin
                push(8'h12);
                push(8'h34);
                push(8'h56);
                push(8'h78);
                check("fifo rdy_full", 32'(rdy), 32'd0);
                check("fifo cnt_full", 32'(cnt), 32'd4);
                push(8'h9A);
                check("fifo cnt_drop", 32'(cnt), 32'd4);
            end
            begin
                expect_frame({1'b1, 8'hA1, 1'b0}, 10, 15, 1'b0, "fifo f1");
                expect_frame({1'b1, 8'h12, 1'b0}, 10, 15, 1'b1, "fifo f2");
                expect_frame({1'b1, 8'h34, 1'b0}, 10, 15, 1'b1, "fifo f3");
                expect_frame({1'b1, 8'h56, 1'b0}, 10, 15, 1'b1, "fifo f4");
                expect_frame({1'b1, 8'h78, 1'b0}, 10, 15, 1'b1, "fifo f5");
            end
        join
        expect_end("fifo");
        repeat (20) @(negedge clk);
        check("fifo no_sixth", 32'(busy), 32'd0);
        check("fifo cnt_empty", 32'(cnt), 32'd0);
        check("fifo done_count", 32'(done_cnt - done_base), 32'd5);

        // Mid-frame config change: frame 1 stays 8N1 div 3, frame 2 is 5E1 div 1
        set_cfg(16'd3, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        fork
            begin
                push(8'h3C);
                push(8'hB5);
                repeat (6) @(negedge clk);
                set_cfg(16'd1, 2'd0, 2'd2, 1'b0);
            end
            begin
                expect_frame({1'b1, 8'h3C, 1'b0}, 10, 3, 1'b0, "cfg f1");
                expect_frame({1'b1, 1'b1, 5'h15, 1'b0}, 8, 1, 1'b1, "cfg f2");
            end
        join
        expect_end("cfg");

        // Flush while frame 1 of 3 is on the line; a push during flush is dropped
        set_cfg(16'd3, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        done_base = done_cnt;
        fork
            begin
                push(8'hC3);
                push(8'h11);
                push(8'h22);
                check("flush cnt_before", 32'(cnt), 32'd2);
                flush = 1'b1;
                push(8'h33);
                flush = 1'b0;
                check("flush cnt_after", 32'(cnt), 32'd0);
                check("flush rdy_after", 32'(rdy), 32'd1);
            end
            begin
                expect_frame({1'b1, 8'hC3, 1'b0}, 10, 3, 1'b0, "flush f1");
            end
        join
        expect_end("flush");
        repeat (40) @(negedge clk);
        check("flush stays_idle", 32'(busy), 32'd0);
        check("flush line_high", 32'(tx), 32'd1);
        check("flush done_count", 32'(done_cnt - done_base), 32'd1);

        // Asynchronous reset during a data bit
        push(8'h00);
        repeat (7) @(negedge clk);
        check("rst in_data_line", 32'(tx), 32'd0);
        check("rst in_data_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async tx", 32'(tx), 32'd1);
        check("rst async rdy", 32'(rdy), 32'd1);
        check("rst async cnt", 32'(cnt), 32'd0);
        check("rst async busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        push(8'h55);
        @(negedge clk);
        expect_frame({1'b1, 8'h55, 1'b0}, 10, 3, 1'b1, "post_rst");
        expect_end("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
